line_burst_adapter: RTL and testbench

LINE_BURST_ADAPTER -- requirements
Module: line_burst_adapter

---
 rtl/line_burst_adapter_pkg.sv | 16 +
 rtl/line_burst_adapter.sv | 107 ++++++++++
 tb/tb_line_burst_adapter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_burst_adapter_pkg.sv
// Shared definitions for the line-to-burst adapter: FSM states and line geometry.
package line_burst_adapter_pkg;

  // Cache line width in bits and the byte-offset width of a line address.
  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;

  // Adapter control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage : line_burst_adapter_pkg

// File: rtl/line_burst_adapter.sv
// Converts single 256-bit line read/write requests into BEATS-long bursts of
// BEAT_W-bit beats. Read beats are assembled into line_rdata lowest beat first;
// write beats are served from a copy of line_wdata taken when the request starts.
module line_burst_adapter
  import line_burst_adapter_pkg::*;
#(
  parameter int BEAT_W = 64,
  parameter int BEATS  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_read,
  input  logic              line_write,
  input  logic [31:0]       line_address,
  input  logic [LINE_W-1:0] line_wdata,
  output logic              line_resp,
  output logic [LINE_W-1:0] line_rdata,
  output logic [31:0]       burst_address,
  output logic              burst_read,
  output logic              burst_write,
  output logic [BEAT_W-1:0] burst_wdata,
  input  logic [BEAT_W-1:0] burst_rdata,
  input  logic              burst_resp
);

  // BEAT_W * BEATS is expected to equal LINE_W; the counter needs at least one bit.
  localparam int              CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  // Clears the byte offset so the burst always starts on a line boundary.
  localparam logic [31:0]     ADDR_MASK = ~32'((1 << OFFSET_W) - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic                burst_read_q, burst_read_d;
  logic                burst_write_q, burst_write_d;

  // Next-state, request capture, beat counting and read-line assembly.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        // Write wins when both requests are present.
        if (line_write || line_read) begin
          state_d = line_write ? WRITE : READ;
          addr_d  = line_address & ADDR_MASK;
          wdata_d = line_wdata;
          cnt_d   = '0;
        end
      end
      READ: begin
        if (burst_resp) begin
          rdata_d[cnt_q*BEAT_W +: BEAT_W] = burst_rdata;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      WRITE: begin
        if (burst_resp) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Burst strobes are flopped copies of the upcoming state, so they rise the
    // cycle after the request is taken and fall right after the last beat.
    burst_read_d  = (state_d == READ);
    burst_write_d = (state_d == WRITE);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      burst_read_q  <= 1'b0;
      burst_write_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      burst_read_q  <= burst_read_d;
      burst_write_q <= burst_write_d;
    end
  end

  assign line_resp     = (state_q == DONE);
  assign line_rdata    = rdata_q;
  assign burst_address = addr_q;
  assign burst_read    = burst_read_q;
  assign burst_write   = burst_write_q;
  assign burst_wdata   = wdata_q[cnt_q*BEAT_W +: BEAT_W];

endmodule : line_burst_adapter

// File: tb/tb_line_burst_adapter.sv
// Directed bench for line_burst_adapter: read, stalled write, priority,
// mid-burst reset, back-to-back and spurious-response scenarios.
module tb_line_burst_adapter;

  localparam int BEAT_W = 64;
  localparam int BEATS  = 4;

  logic               clk;
  logic               rst_n;
  logic               line_read;
  logic               line_write;
  logic [31:0]        line_address;
  logic [255:0]       line_wdata;
  logic               line_resp;
  logic [255:0]       line_rdata;
  logic [31:0]        burst_address;
  logic               burst_read;
  logic               burst_write;
  logic [BEAT_W-1:0]  burst_wdata;
  logic [BEAT_W-1:0]  burst_rdata;
  logic               burst_resp;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [255:0] last_line;  // line the bench expects line_rdata to hold

  line_burst_adapter #(.BEAT_W(BEAT_W), .BEATS(BEATS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .line_read     (line_read),
    .line_write    (line_write),
    .line_address  (line_address),
    .line_wdata    (line_wdata),
    .line_resp     (line_resp),
    .line_rdata    (line_rdata),
    .burst_address (burst_address),
    .burst_read    (burst_read),
    .burst_write   (burst_write),
    .burst_wdata   (burst_wdata),
    .burst_rdata   (burst_rdata),
    .burst_resp    (burst_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are observed 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; line_read = 1'b0; line_write = 1'b0; line_address = '0;
    line_wdata = '0; burst_rdata = '0; burst_resp = 1'b0;
    tick();
    tests_run++;
    if ({line_resp, burst_read, burst_write} !== 3'b000 || line_rdata !== '0 ||
        burst_address !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: resp/rd/wr=%b rdata=%h addr=%h required all zero",
               {line_resp, burst_read, burst_write}, line_rdata, burst_address);
    end
    rst_n = 1'b1;
    tick();
    $display("[TB] reset released");
  endtask

  task automatic test_read_zero_wait();
    logic [63:0] beats [4];
    logic [255:0] exp_line;
    int edges;
    beats[0] = 64'h1111_1111_1111_1111; beats[1] = 64'h2222_2222_2222_2222;
    beats[2] = 64'h3333_3333_3333_3333; beats[3] = 64'h4444_4444_4444_4444;
    exp_line = {beats[3], beats[2], beats[1], beats[0]};
    line_address = 32'h1234_5678; line_read = 1'b1;
    tick(); edges = 1;
    line_address = 32'hFFFF_FFFF;  // must be ignored from here on
    tests_run++;
    if (burst_read !== 1'b1 || burst_write !== 1'b0 || burst_address !== 32'h1234_5660) begin
      tests_failed++;
      $display("FAIL read_start: rd=%b wr=%b addr=%h required rd=1 wr=0 addr=12345660",
               burst_read, burst_write, burst_address);
    end
    for (int k = 0; k < 4; k++) begin
      burst_rdata = beats[k]; burst_resp = 1'b1;
      tick(); edges++;
      tests_run++;
      if (burst_read !== (k < 3) || line_resp !== (k == 3) || burst_address !== 32'h1234_5660) begin
        tests_failed++;
        $display("FAIL read_beat%0d: rd=%b resp=%b addr=%h required rd=%b resp=%b addr=12345660",
                 k, burst_read, line_resp, burst_address, (k < 3), (k == 3));
      end
    end
    burst_resp = 1'b0; line_read = 1'b0;
    tests_run++;
    if (edges !== 5 || line_rdata !== exp_line) begin
      tests_failed++;
      $display("FAIL read_line: edges=%0d rdata=%h required edges=5 rdata=%h", edges, line_rdata, exp_line);
    end
    tick();
    tests_run++;
    if (line_resp !== 1'b0 || burst_read !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_resp_width: resp=%b rd=%b required 0 0", line_resp, burst_read);
    end
    last_line = exp_line;
    $display("[TB] zero-wait read done, line=%h", line_rdata);
  endtask

  task automatic test_write_stalls();
    logic [6:0] pattern;
    logic [63:0] exp_beat;
    int k;
    pattern = 7'b1011001;  // applied LSB first: 1,0,0,1,1,0,1
    line_address = 32'h0000_0044; line_write = 1'b1;
    line_wdata = {32'hDEADBEEF, 32'd3, 32'hDEADBEEF, 32'd2,
                  32'hDEADBEEF, 32'd1, 32'hDEADBEEF, 32'd0};
    tick();
    line_wdata = '0;  // must be ignored
    k = 0;
    for (int i = 0; i < 7; i++) begin
      exp_beat = {32'hDEADBEEF, 32'(k)};
      tests_run++;
      if (burst_write !== 1'b1 || burst_read !== 1'b0 || burst_wdata !== exp_beat ||
          burst_address !== 32'h0000_0040) begin
        tests_failed++;
        $display("FAIL write_cycle%0d: wr=%b rd=%b wdata=%h addr=%h required wr=1 rd=0 wdata=%h addr=00000040",
                 i, burst_write, burst_read, burst_wdata, burst_address, exp_beat);
      end
      burst_resp = pattern[i];
      tick();
      if (pattern[i]) k++;
    end
    burst_resp = 1'b0;
    tests_run++;
    if (burst_write !== 1'b0 || line_resp !== 1'b1 || line_rdata !== last_line) begin
      tests_failed++;
      $display("FAIL write_end: wr=%b resp=%b rdata=%h required wr=0 resp=1 rdata=%h",
               burst_write, line_resp, line_rdata, last_line);
    end
    line_write = 1'b0;
    tick();
    $display("[TB] stalled write done");
  endtask

  task automatic test_both_requests();
    line_address = 32'h0000_00A0; line_read = 1'b1; line_write = 1'b1;
    line_wdata = {4{64'h0123_4567_89AB_CDEF}};
    tick();
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (burst_write !== 1'b1 || burst_read !== 1'b0) begin
        tests_failed++;
        $display("FAIL both_beat%0d: wr=%b rd=%b required wr=1 rd=0", k, burst_write, burst_read);
      end
      burst_resp = 1'b1;
      tick();
    end
    burst_resp = 1'b0;
    tests_run++;
    if (line_resp !== 1'b1 || burst_read !== 1'b0 || line_rdata !== last_line) begin
      tests_failed++;
      $display("FAIL both_end: resp=%b rd=%b rdata=%h required resp=1 rd=0 rdata=%h",
               line_resp, burst_read, line_rdata, last_line);
    end
    line_read = 1'b0; line_write = 1'b0;
    tick();
    $display("[TB] simultaneous request handled as write");
  endtask

  task automatic test_reset_mid_burst();
    logic [255:0] exp_line;
    line_address = 32'h0000_1040; line_read = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      burst_rdata = {8{8'hA0 + 8'(k)}}; burst_resp = 1'b1;
      tick();
    end
    burst_resp = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({line_resp, burst_read, burst_write} !== 3'b000 || line_rdata !== '0 || burst_address !== '0) begin
      tests_failed++;
      $display("FAIL reset_async: resp/rd/wr=%b rdata=%h addr=%h required all zero",
               {line_resp, burst_read, burst_write}, line_rdata, burst_address);
    end
    line_read = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++;
      if (line_resp !== 1'b0 || burst_read !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_hold%0d: resp=%b rd=%b required 0 0", i, line_resp, burst_read);
      end
    end
    rst_n = 1'b1;
    tick();
    // Fresh read after reset.
    exp_line = {64'hB3B3_B3B3_B3B3_B3B3, 64'hB2B2_B2B2_B2B2_B2B2,
                64'hB1B1_B1B1_B1B1_B1B1, 64'hB0B0_B0B0_B0B0_B0B0};
    line_address = 32'h0000_2020; line_read = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      burst_rdata = exp_line[k*64 +: 64]; burst_resp = 1'b1;
      tick();
    end
    burst_resp = 1'b0;
    tests_run++;
    if (line_resp !== 1'b1 || line_rdata !== exp_line || burst_address !== 32'h0000_2020) begin
      tests_failed++;
      $display("FAIL reset_reread: resp=%b rdata=%h addr=%h required resp=1 rdata=%h addr=00002020",
               line_resp, line_rdata, burst_address, exp_line);
    end
    line_read = 1'b0;
    tick();
    last_line = exp_line;
    $display("[TB] mid-burst reset and recovery done");
  endtask

  task automatic test_back_to_back();
    logic [255:0] exp_line;
    exp_line = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
    line_address = 32'h0000_3000; line_write = 1'b1; line_wdata = {4{64'h5A5A}};
    tick();
    burst_resp = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    burst_resp = 1'b0;
    tests_run++;
    if (line_resp !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_write_resp: resp=%b required 1", line_resp);
    end
    // Upstream switches straight to a read in the line_resp cycle.
    line_write = 1'b0; line_read = 1'b1;
    tick();
    tests_run++;
    if (burst_read !== 1'b0 || line_resp !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_gap: rd=%b resp=%b required 0 0", burst_read, line_resp);
    end
    tick();
    tests_run++;
    if (burst_read !== 1'b1 || burst_address !== 32'h0000_3000) begin
      tests_failed++;
      $display("FAIL b2b_read_start: rd=%b addr=%h required rd=1 addr=00003000", burst_read, burst_address);
    end
    for (int k = 0; k < 4; k++) begin
      burst_rdata = exp_line[k*64 +: 64]; burst_resp = 1'b1;
      tick();
    end
    burst_resp = 1'b0;
    tests_run++;
    if (line_resp !== 1'b1 || line_rdata !== exp_line) begin
      tests_failed++;
      $display("FAIL b2b_read_end: resp=%b rdata=%h required resp=1 rdata=%h", line_resp, line_rdata, exp_line);
    end
    line_read = 1'b0;
    tick();
    last_line = exp_line;
    $display("[TB] back-to-back write/read done");
  endtask

  task automatic test_spurious_resp();
    burst_resp = 1'b1; burst_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if ({line_resp, burst_read, burst_write} !== 3'b000 || line_rdata !== last_line) begin
        tests_failed++;
        $display("FAIL spurious%0d: resp/rd/wr=%b rdata=%h required 000 rdata=%h",
                 i, {line_resp, burst_read, burst_write}, line_rdata, last_line);
      end
    end
    burst_resp = 1'b0;
    $display("[TB] spurious burst_resp ignored");
  endtask

  initial begin
    last_line = '0;
    test_reset();
    test_read_zero_wait();
    test_write_stalls();
    test_both_requests();
    test_reset_mid_burst();
    test_back_to_back();
    test_spurious_resp();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_line_burst_adapter
